// File: rtl/melody_pkg.sv
// ---------------------------------------------------------------------------
// melody_pkg
// Shared types and constants for the melody sequencer slice.
//   note_t   : packed ROM word {freq[19:0], dur[7:0]}; dur == 0 marks end of song,
//              freq == 0 with dur != 0 is a rest.
//   NOTE_*   : note frequencies in Hz used to build the song ROM.
//   SONG_LEN : number of ROM slots per song.
//   state_t  : sequencer FSM states.
// ---------------------------------------------------------------------------
package melody_pkg;

    localparam int FREQ_W   = 20;
    localparam int DUR_W    = 8;
    localparam int SONG_LEN = 16;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [DUR_W-1:0]  dur;
    } note_t;

    localparam logic [FREQ_W-1:0] NOTE_REST = 20'd0;
    localparam logic [FREQ_W-1:0] NOTE_C4   = 20'd262;
    localparam logic [FREQ_W-1:0] NOTE_D4   = 20'd294;
    localparam logic [FREQ_W-1:0] NOTE_E4   = 20'd330;
    localparam logic [FREQ_W-1:0] NOTE_F4   = 20'd349;
    localparam logic [FREQ_W-1:0] NOTE_G4   = 20'd392;
    localparam logic [FREQ_W-1:0] NOTE_A4   = 20'd440;
    localparam logic [FREQ_W-1:0] NOTE_B4   = 20'd494;
    localparam logic [FREQ_W-1:0] NOTE_C5   = 20'd523;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Builds one ROM word from a frequency and a duration in ticks.
    function automatic note_t mk_note(input logic [FREQ_W-1:0] f, input logic [DUR_W-1:0] d);
        note_t n;
        n.freq = f;
        n.dur  = d;
        return n;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// ---------------------------------------------------------------------------
// melody_rom
// Synchronous 64 x 28 note ROM, four songs of SONG_LEN entries each.
// Song s lives at addresses s*16 .. s*16+15. Unlisted addresses read as the
// end-of-song marker (all zero).
// Ports:
//   clk  in   system clock
//   addr in   6-bit address {song[1:0], index[3:0]}
//   data out  note_t word, valid one cycle after addr is presented
// ---------------------------------------------------------------------------
module melody_rom
    import melody_pkg::*;
(
    input  logic       clk,
    input  logic [5:0] addr,
    output note_t      data
);

    note_t data_d;
    note_t data_q;

    always_comb begin
        data_d = '0;
        case (addr)
            // song 0: short two-note jingle
            6'd0:  data_d = mk_note(NOTE_C4, 8'd3);
            6'd1:  data_d = mk_note(NOTE_E4, 8'd2);
            // song 1: note, rest, note
            6'd16: data_d = mk_note(NOTE_G4, 8'd2);
            6'd17: data_d = mk_note(NOTE_REST, 8'd4);
            6'd18: data_d = mk_note(NOTE_C5, 8'd1);
            // song 2: full 16-note scale up and down, no end marker
            6'd32: data_d = mk_note(NOTE_C4, 8'd1);
            6'd33: data_d = mk_note(NOTE_D4, 8'd1);
            6'd34: data_d = mk_note(NOTE_E4, 8'd1);
            6'd35: data_d = mk_note(NOTE_F4, 8'd1);
            6'd36: data_d = mk_note(NOTE_G4, 8'd1);
            6'd37: data_d = mk_note(NOTE_A4, 8'd1);
            6'd38: data_d = mk_note(NOTE_B4, 8'd1);
            6'd39: data_d = mk_note(NOTE_C5, 8'd1);
            6'd40: data_d = mk_note(NOTE_C5, 8'd1);
            6'd41: data_d = mk_note(NOTE_B4, 8'd1);
            6'd42: data_d = mk_note(NOTE_A4, 8'd1);
            6'd43: data_d = mk_note(NOTE_G4, 8'd1);
            6'd44: data_d = mk_note(NOTE_F4, 8'd1);
            6'd45: data_d = mk_note(NOTE_E4, 8'd1);
            6'd46: data_d = mk_note(NOTE_D4, 8'd1);
            6'd47: data_d = mk_note(NOTE_C4, 8'd1);
            // song 3: descending arpeggio
            6'd48: data_d = mk_note(NOTE_C5, 8'd1);
            6'd49: data_d = mk_note(NOTE_G4, 8'd1);
            6'd50: data_d = mk_note(NOTE_E4, 8'd1);
            6'd51: data_d = mk_note(NOTE_C4, 8'd2);
            default: data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
// Walks one of four songs in melody_rom and drives the buzzer stage with a
// per-note frequency and enable, holding each note for dur ticks (one tick =
// CLK_HZ/100 cycles) and inserting GAP_TICKS silent ticks between notes.
// Optional feature: define MELODY_LOOP_EN to restart the same song after each
// completion until stop or reset.
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   GAP_TICKS  silent ticks after every note that is not the last slot
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   start    in   single-cycle play request for song_sel
//   stop     in   single-cycle abort (wins over start)
//   song_sel in   song index, captured when start is accepted
//   freq     out  note frequency in Hz, 0 when silent
//   enable   out  buzzer enable
//   busy     out  high while a song is in progress
//   done     out  one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int GAP_TICKS = 2
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        song_sel,
    output logic [FREQ_W-1:0] freq,
    output logic              enable,
    output logic              busy,
    output logic              done
);

    localparam int TICK_CYCLES = CLK_HZ / 100;
    localparam int TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = (GAP_TICKS > 0) ? DUR_W'(GAP_TICKS - 1) : '0;
    localparam logic [3:0]        LAST_IDX  = 4'(SONG_LEN - 1);

    state_t             state_q, state_d;
    logic [1:0]         song_q, song_d;
    logic [3:0]         idx_q, idx_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    note_t              note_q, note_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    note_t              rom_data;
    logic               tick_done;

    melody_rom u_rom (
        .clk  (clk),
        .addr ({song_q, idx_q}),
        .data (rom_data)
    );

    assign tick_done = (tick_q == TICK_LAST);

    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        idx_d     = idx_q;
        tick_d    = tick_q;
        dur_cnt_d = dur_cnt_q;
        note_d    = note_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_FETCH;
                    song_d  = song_sel;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                if (rom_data.dur == '0) begin
                    state_d = S_DONE;
                end else begin
                    note_d    = rom_data;
                    tick_d    = '0;
                    dur_cnt_d = '0;
                    state_d   = S_PLAY;
                end
            end
            S_PLAY: begin
                // dur_cnt counts completed ticks of the current note
                if (tick_done) begin
                    tick_d = '0;
                    if (dur_cnt_q == note_q.dur - 8'd1) begin
                        dur_cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = (GAP_TICKS == 0) ? S_FETCH : S_GAP;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q + 8'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_GAP: begin
                // dur_cnt is reused here to count elapsed gap ticks
                if (tick_done) begin
                    tick_d = '0;
                    if (dur_cnt_q == GAP_LAST) begin
                        dur_cnt_d = '0;
                        state_d   = S_FETCH;
                    end else begin
                        dur_cnt_d = dur_cnt_q + 8'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DONE: begin
`ifdef MELODY_LOOP_EN
                state_d = S_FETCH;
                idx_d   = '0;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides whatever the state machine decided this cycle
        if (stop && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            tick_d    = '0;
            dur_cnt_d = '0;
        end

        // outputs are registered copies of what the next state will present
        freq_d   = (state_d == S_PLAY) ? note_d.freq : '0;
        enable_d = (state_d == S_PLAY) && (note_d.freq != '0);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            song_q    <= '0;
            idx_q     <= '0;
            tick_q    <= '0;
            dur_cnt_q <= '0;
            note_q    <= '0;
            freq_q    <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            idx_q     <= idx_d;
            tick_q    <= tick_d;
            dur_cnt_q <= dur_cnt_d;
            note_q    <= note_d;
            freq_q    <= freq_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign freq   = freq_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// ---------------------------------------------------------------------------
// tb_melody_sequencer
// Plays songs on melody_sequencer with a 1 kHz clock (10-cycle ticks) and
// compares every cycle of freq/enable/busy/done against a cycle list built
// from the song table and the playback rules. Random song choice, random
// abort points (stop or reset) and random ignored start pulses.
// ---------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam int CLK_HZ    = 1000;
    localparam int GAP_TICKS = 2;
    localparam int T         = CLK_HZ / 100;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [1:0]  song_sel;
    logic [19:0] freq;
    logic        enable;
    logic        busy;
    logic        done;

    int total;
    int bad;

    typedef struct {
        int f;
        bit en;
        bit bz;
        bit dn;
    } cyc_t;

    cyc_t expQ[$];
    int   songF[4][16];
    int   songD[4][16];
    bit   loopMode;

    melody_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .song_sel (song_sel),
        .freq     (freq),
        .enable   (enable),
        .busy     (busy),
        .done     (done)
    );

    // free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // counts one comparison and reports it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // compares all four outputs against one expected cycle
    task automatic checkCycle(input string tag, input cyc_t e);
        checkOutput({tag, " freq"},   32'(freq),   32'(e.f));
        checkOutput({tag, " enable"}, 32'(enable), 32'(e.en));
        checkOutput({tag, " busy"},   32'(busy),   32'(e.bz));
        checkOutput({tag, " done"},   32'(done),   32'(e.dn));
    endtask

    function automatic void pushCyc(input int f, input bit en, input bit bz, input bit dn, input int n);
        cyc_t c;
        c.f  = f;
        c.en = en;
        c.bz = bz;
        c.dn = dn;
        for (int i = 0; i < n; i++) expQ.push_back(c);
    endfunction

    // output sequence seen after each edge, starting with the edge that accepts start
    function automatic void buildExpected(input int s);
        int idx;
        bit finished;
        expQ.delete();
        idx = 0;
        finished = 0;
        while (!finished && expQ.size() < 1500) begin
            pushCyc(0, 0, 1, 0, 2);
            if (songD[s][idx] == 0) begin
                pushCyc(0, 0, 1, 1, 1);
                if (loopMode) idx = 0; else finished = 1;
            end else begin
                pushCyc(songF[s][idx], songF[s][idx] != 0, 1, 0, songD[s][idx] * T);
                if (idx == 15) begin
                    pushCyc(0, 0, 1, 1, 1);
                    if (loopMode) idx = 0; else finished = 1;
                end else begin
                    pushCyc(0, 0, 1, 0, GAP_TICKS * T);
                    idx++;
                end
            end
        end
        if (!loopMode) pushCyc(0, 0, 0, 0, 3);
    endfunction

    // plays song s; abortAt >= 0 aborts (stop or reset) after that cycle,
    // startAt >= 0 pulses a competing start that must be ignored
    task automatic applyStimulus(input int s, input int abortAt, input bit useReset, input int startAt);
        cyc_t idle;
        int   abortIdx;
        idle.f = 0; idle.en = 0; idle.bz = 0; idle.dn = 0;
        buildExpected(s);
        abortIdx = abortAt;
        if (loopMode && abortIdx < 0) abortIdx = expQ.size() - 1;
        start    = 1'b1;
        song_sel = 2'(s);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < expQ.size(); j++) begin
            checkCycle($sformatf("song%0d cyc%0d", s, j), expQ[j]);
            if (j == abortIdx) begin
                if (useReset) reset = 1'b1; else stop = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                stop  = 1'b0;
                checkCycle($sformatf("song%0d abort%0d", s, j), idle);
                break;
            end
            if (j == startAt && expQ[j].bz) begin
                start    = 1'b1;
                song_sel = 2'(s + 1 + int'($urandom_range(0, 2)));
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        cyc_t idle;
        int   s;
        int   abortAt;
        idle.f = 0; idle.en = 0; idle.bz = 0; idle.dn = 0;
        total = 0;
        bad   = 0;
`ifdef MELODY_LOOP_EN
        loopMode = 1'b1;
`else
        loopMode = 1'b0;
`endif
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 16; b++) begin
                songF[a][b] = 0;
                songD[a][b] = 0;
            end
        end
        songF[0][0] = 262; songD[0][0] = 3;
        songF[0][1] = 330; songD[0][1] = 2;
        songF[1][0] = 392; songD[1][0] = 2;
        songF[1][1] = 0;   songD[1][1] = 4;
        songF[1][2] = 523; songD[1][2] = 1;
        songF[2] = '{262, 294, 330, 349, 392, 440, 494, 523, 523, 494, 440, 392, 349, 330, 294, 262};
        for (int b = 0; b < 16; b++) songD[2][b] = 1;
        songF[3][0] = 523; songD[3][0] = 1;
        songF[3][1] = 392; songD[3][1] = 1;
        songF[3][2] = 330; songD[3][2] = 1;
        songF[3][3] = 262; songD[3][3] = 2;

        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        song_sel = 2'd0;
        @(negedge clk);
        @(negedge clk);
        checkCycle("reset", idle);
        reset = 1'b0;
        @(negedge clk);
        checkCycle("idle", idle);

        $display("[TB] song 0 full playback");
        applyStimulus(0, -1, 1'b0, -1);
        $display("[TB] song 1 with rest");
        applyStimulus(1, -1, 1'b0, -1);
        $display("[TB] song 0 stop five cycles into first note");
        applyStimulus(0, 6, 1'b0, -1);
        $display("[TB] song 2 sixteen notes with ignored start");
        applyStimulus(2, -1, 1'b0, 100);
        $display("[TB] song 3 reset mid-song");
        applyStimulus(3, 25, 1'b1, 10);

        // stop and start together in IDLE: nothing starts
        start    = 1'b1;
        stop     = 1'b1;
        song_sel = 2'd1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checkCycle("start_with_stop", idle);
        @(negedge clk);
        checkCycle("start_with_stop_after", idle);

        $display("[TB] randomized playback");
        for (int r = 0; r < 12; r++) begin
            s = int'($urandom_range(0, 3));
            buildExpected(s);
            abortAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, expQ.size() - 1)) : -1;
            applyStimulus(s, abortAt, $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, expQ.size() - 1)));
            @(negedge clk);
            checkCycle($sformatf("rand%0d idle", r), idle);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
